apb_master_bridge: RTL and testbench

Downstream neighbour of the RV32I core's data bus. It takes the core's load/store request (address, write enable, write data, byte enables) and converts it into an APB4 transfer to one of NUM_SLV memory-mapped slaves. Slaves are RAM, GPIO, UART, timer and so on. The bridge returns read data and a ready strobe, which the core uses to stall its single-cycle datapath until the transfer completes.

---
 rtl/apb_pkg.sv | 19 +
 rtl/apb_addr_decoder.sv | 27 ++
 rtl/apb_master_bridge.sv | 135 +++++++++++++
 tb/tb_apb_master_bridge.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// apb_pkg: shared types and constants for the APB master bridge.
//   Contents: FSM state enum, slave-index width helper, default address map,
//   timeout read-data pattern.
package apb_pkg;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_e;

    localparam int          DEF_NUM_SLV       = 4;
    localparam logic [31:0] DEF_BASE_ADDR     = 32'h1000_0000;
    localparam int          DEF_SLV_SIZE_LOG2 = 12;
    localparam int          DEF_TIMEOUT_CYC   = 16;
    localparam logic [31:0] APB_TIMEOUT_DATA  = 32'hDEAD_BEEF;

    // A single-slave system still needs a 1-bit index.
    function automatic int apb_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/apb_addr_decoder.sv
// apb_addr_decoder: maps a core byte address to an APB slave index.
//   addr_i   : core byte address
//   idx_o    : slave index (0 when unmapped)
//   mapped_o : address falls inside one of the NUM_SLV windows
module apb_addr_decoder
    import apb_pkg::*;
#(
    parameter int          NUM_SLV       = DEF_NUM_SLV,
    parameter logic [31:0] BASE_ADDR     = DEF_BASE_ADDR,
    parameter int          SLV_SIZE_LOG2 = DEF_SLV_SIZE_LOG2
) (
    input  logic [31:0]                    addr_i,
    output logic [apb_idx_w(NUM_SLV)-1:0]  idx_o,
    output logic                           mapped_o
);

    localparam int IDX_W = apb_idx_w(NUM_SLV);

    logic [31:0] slot;

    // Addresses below the base wrap to huge slot numbers; the explicit
    // lower-bound compare rejects them regardless.
    assign slot     = (addr_i - BASE_ADDR) >> SLV_SIZE_LOG2;
    assign mapped_o = (addr_i >= BASE_ADDR) && (slot < 32'(NUM_SLV));
    assign idx_o    = mapped_o ? slot[IDX_W-1:0] : '0;

endmodule

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: converts core data-bus requests into APB4 transfers.
//   Core side : cpuReq/cpuWe/cpuAddr/cpuWData/cpuByteEn in,
//               cpuRData/cpuReady/cpuErr out (ready is a one-cycle strobe).
//   APB side  : PADDR/PWRITE/PWDATA/PSTRB/PSEL/PENABLE out,
//               per-slave PRDATA/PREADY/PSLVERR in.
//   Option    : define APB_TIMEOUT_EN to abort transfers whose slave keeps
//               PREADY low for TIMEOUT_CYC access cycles.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int          NUM_SLV       = DEF_NUM_SLV,
    parameter logic [31:0] BASE_ADDR     = DEF_BASE_ADDR,
    parameter int          SLV_SIZE_LOG2 = DEF_SLV_SIZE_LOG2
`ifdef APB_TIMEOUT_EN
    ,
    parameter int          TIMEOUT_CYC   = DEF_TIMEOUT_CYC
`endif
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cpuReq,
    input  logic                     cpuWe,
    input  logic [31:0]              cpuAddr,
    input  logic [31:0]              cpuWData,
    input  logic [3:0]               cpuByteEn,
    output logic [31:0]              cpuRData,
    output logic                     cpuReady,
    output logic                     cpuErr,
    output logic [31:0]              PADDR,
    output logic                     PWRITE,
    output logic [31:0]              PWDATA,
    output logic [3:0]               PSTRB,
    output logic [NUM_SLV-1:0]       PSEL,
    output logic                     PENABLE,
    input  logic [NUM_SLV-1:0][31:0] PRDATA,
    input  logic [NUM_SLV-1:0]       PREADY,
    input  logic [NUM_SLV-1:0]       PSLVERR
);

    localparam int                 IDX_W   = apb_idx_w(NUM_SLV);
    localparam logic [NUM_SLV-1:0] SEL_ONE = NUM_SLV'(1);

    apb_state_e        state_q, state_d;
    logic [31:0]       addr_q, wdata_q;
    logic [3:0]        strb_q;
    logic              we_q, mapped_q;
    logic [IDX_W-1:0]  idx_q, dec_idx;
    logic              dec_mapped, timeout, done;

    apb_addr_decoder #(
        .NUM_SLV       (NUM_SLV),
        .BASE_ADDR     (BASE_ADDR),
        .SLV_SIZE_LOG2 (SLV_SIZE_LOG2)
    ) u_dec (
        .addr_i   (cpuAddr),
        .idx_o    (dec_idx),
        .mapped_o (dec_mapped)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            strb_q   <= '0;
            we_q     <= 1'b0;
            idx_q    <= '0;
            mapped_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && cpuReq) begin
                addr_q   <= cpuAddr;
                wdata_q  <= cpuWData;
                strb_q   <= cpuWe ? cpuByteEn : 4'b0000;
                we_q     <= cpuWe;
                idx_q    <= dec_idx;
                mapped_q <= dec_mapped;
            end
        end
    end

`ifdef APB_TIMEOUT_EN
    logic [4:0] wait_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            wait_q <= '0;
        else if (state_q == SETUP)
            wait_q <= '0;
        else if (state_q == ACCESS && !PREADY[idx_q])
            wait_q <= wait_q + 5'd1;
    end

    assign timeout = (wait_q == 5'(TIMEOUT_CYC));
`else
    assign timeout = 1'b0;
`endif

    // Unmapped transfers finish on their first access cycle with an error.
    assign done = !mapped_q || PREADY[idx_q] || timeout;

    assign PADDR  = addr_q;
    assign PWRITE = we_q;
    assign PWDATA = wdata_q;
    assign PSTRB  = strb_q;

    always_comb begin
        state_d  = state_q;
        PSEL     = '0;
        PENABLE  = 1'b0;
        cpuReady = 1'b0;
        cpuErr   = 1'b0;
        cpuRData = '0;
        unique case (state_q)
            IDLE:  state_d = cpuReq ? SETUP : IDLE;
            SETUP: begin
                PSEL    = mapped_q ? SEL_ONE << idx_q : '0;
                state_d = ACCESS;
            end
            ACCESS: begin
                PSEL     = mapped_q ? SEL_ONE << idx_q : '0;
                PENABLE  = 1'b1;
                cpuReady = done;
                // Completing without PREADY can only mean unmapped or timed out.
                cpuErr   = done && (!mapped_q || !PREADY[idx_q] || PSLVERR[idx_q]);
                cpuRData = (!done || !mapped_q) ? '0 :
                           PREADY[idx_q] ? (we_q ? '0 : PRDATA[idx_q]) :
                           APB_TIMEOUT_DATA;
                state_d  = done ? IDLE : ACCESS;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge: table-driven self-checking bench for apb_master_bridge.
module tb_apb_master_bridge;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              cpuReq = 1'b0, cpuWe = 1'b0;
    logic [31:0]       cpuAddr = '0, cpuWData = '0;
    logic [3:0]        cpuByteEn = '0;
    logic [31:0]       cpuRData;
    logic              cpuReady, cpuErr;
    logic [31:0]       PADDR, PWDATA;
    logic              PWRITE, PENABLE;
    logic [3:0]        PSTRB, PSEL;
    logic [3:0][31:0]  PRDATA = '0;
    logic [3:0]        PREADY = '1, PSLVERR = '0;

    always #5 clk = ~clk;

    apb_master_bridge dut (
        .clk(clk), .reset(reset),
        .cpuReq(cpuReq), .cpuWe(cpuWe), .cpuAddr(cpuAddr), .cpuWData(cpuWData),
        .cpuByteEn(cpuByteEn), .cpuRData(cpuRData), .cpuReady(cpuReady), .cpuErr(cpuErr),
        .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB),
        .PSEL(PSEL), .PENABLE(PENABLE),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          slv;
        int          wt;
        logic [31:0] prdata;
        logic        slverr;
        logic [3:0]  psel;
        logic [3:0]  pstrb;
        logic        err;
        logic [31:0] rdata;
    } vec_t;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[9];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic pop_chk(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL %s: got unexpected completion expected none", name);
        end else begin
            e = sb.pop_front();
            chk({name, "_err"}, 32'(cpuErr), 32'(e.err));
            chk({name, "_rdata"}, cpuRData, e.rdata);
        end
    endtask

    // Target slave follows rdy/d/e; every other slave is ready, errors and
    // returns junk so a wrong mux select is visible.
    task automatic set_slaves(input int slv, input logic rdy, input logic [31:0] d, input logic e);
        for (int s = 0; s < 4; s++) begin
            PREADY[s]  = (s == slv) ? rdy : 1'b1;
            PRDATA[s]  = (s == slv) ? d : (32'hBAD0_0000 | 32'(s));
            PSLVERR[s] = (s == slv) ? e : 1'b1;
        end
    endtask

    task automatic drive_req(input logic we, input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] be);
        @(posedge clk);
        #1;
        cpuReq    = 1'b1;
        cpuWe     = we;
        cpuAddr   = addr;
        cpuWData  = wd;
        cpuByteEn = be;
    endtask

    task automatic run(input vec_t v);
        int   n;
        logic done;
        exp_t e;
        drive_req(v.we, v.addr, v.wdata, v.be);
        set_slaves(v.slv, v.wt == 0, v.prdata, v.slverr);
        e.err   = v.err;
        e.rdata = v.rdata;
        sb.push_back(e);
        @(negedge clk);
        chk("idle_psel", 32'(PSEL), 32'h0);
        chk("idle_ready", 32'(cpuReady), 32'h0);
        @(negedge clk);
        chk("setup_psel", 32'(PSEL), 32'(v.psel));
        chk("setup_penable", 32'(PENABLE), 32'h0);
        chk("setup_paddr", PADDR, v.addr);
        chk("setup_pwrite", 32'(PWRITE), 32'(v.we));
        chk("setup_pwdata", PWDATA, v.wdata);
        chk("setup_pstrb", 32'(PSTRB), 32'(v.pstrb));
        chk("setup_ready", 32'(cpuReady), 32'h0);
        n = 0;
        done = 1'b0;
        while (!done && n < 64) begin
            @(posedge clk);
            #1;
            set_slaves(v.slv, n >= v.wt, v.prdata, v.slverr);
            @(negedge clk);
            chk("acc_penable", 32'(PENABLE), 32'h1);
            chk("acc_psel", 32'(PSEL), 32'(v.psel));
            chk("acc_paddr", PADDR, v.addr);
            chk("acc_pstrb", 32'(PSTRB), 32'(v.pstrb));
            if (cpuReady) begin
                done = 1'b1;
                pop_chk("cmp");
                chk("latency", 32'(n), (v.slv < 0) ? 32'h0 : 32'(v.wt));
            end else begin
                n++;
            end
        end
        if (!done) chk("no_completion", 32'h0, 32'h1);
        @(posedge clk);
        #1;
        cpuReq = 1'b0;
        set_slaves(-1, 1'b1, '0, 1'b0);
        @(negedge clk);
        chk("post_psel", 32'(PSEL), 32'h0);
        chk("post_penable", 32'(PENABLE), 32'h0);
        chk("post_ready", 32'(cpuReady), 32'h0);
        chk("post_err", 32'(cpuErr), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        logic done;
        exp_t e;
        //            we    addr           wdata          be       slv wt prdata         serr  psel     pstrb    err   rdata
        tbl[0] = '{1'b1, 32'h1000_0004, 32'hA5A5_1234, 4'b1111,  0, 0, 32'h0,         1'b0, 4'b0001, 4'b1111, 1'b0, 32'h0};
        tbl[1] = '{1'b0, 32'h1000_2010, 32'h1111_1111, 4'b1111,  2, 3, 32'h0000_00FF, 1'b0, 4'b0100, 4'b0000, 1'b0, 32'h0000_00FF};
        tbl[2] = '{1'b1, 32'h1000_1002, 32'hBEEF_0000, 4'b1100,  1, 0, 32'h0,         1'b0, 4'b0010, 4'b1100, 1'b0, 32'h0};
        tbl[3] = '{1'b0, 32'h2000_0000, 32'h2222_2222, 4'b1111, -1, 0, 32'h0,         1'b0, 4'b0000, 4'b0000, 1'b1, 32'h0};
        tbl[4] = '{1'b0, 32'h0FFF_FFFC, 32'h3333_3333, 4'b1111, -1, 0, 32'h0,         1'b0, 4'b0000, 4'b0000, 1'b1, 32'h0};
        tbl[5] = '{1'b0, 32'h1000_3FFC, 32'h4444_4444, 4'b1111,  3, 1, 32'h1234_5678, 1'b1, 4'b1000, 4'b0000, 1'b1, 32'h1234_5678};
        tbl[6] = '{1'b0, 32'h1000_4000, 32'h5555_5555, 4'b1111, -1, 0, 32'h0,         1'b0, 4'b0000, 4'b0000, 1'b1, 32'h0};
        tbl[7] = '{1'b1, 32'h1000_3008, 32'h00FF_00FF, 4'b0101,  3, 2, 32'h0,         1'b0, 4'b1000, 4'b0101, 1'b0, 32'h0};
        tbl[8] = '{1'b0, 32'h1000_0FFC, 32'h6666_6666, 4'b1111,  0, 0, 32'hCAFE_F00D, 1'b0, 4'b0001, 4'b0000, 1'b0, 32'hCAFE_F00D};

        #1;
        chk("rst_psel", 32'(PSEL), 32'h0);
        chk("rst_penable", 32'(PENABLE), 32'h0);
        chk("rst_paddr", PADDR, 32'h0);
        chk("rst_pwdata", PWDATA, 32'h0);
        chk("rst_pstrb", 32'(PSTRB), 32'h0);
        chk("rst_pwrite", 32'(PWRITE), 32'h0);
        chk("rst_ready", 32'(cpuReady), 32'h0);
        chk("rst_err", 32'(cpuErr), 32'h0);
        chk("rst_rdata", cpuRData, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;

        for (int i = 0; i < 9; i++) run(tbl[i]);

        // Reset in the middle of an access phase aborts with no completion.
        drive_req(1'b0, 32'h1000_3000, 32'h7777_7777, 4'b1111);
        set_slaves(3, 1'b0, 32'h9999_9999, 1'b0);
        repeat (3) @(negedge clk);
        chk("abort_pre_penable", 32'(PENABLE), 32'h1);
        #2;
        reset = 1'b0;
        #1;
        chk("abort_psel", 32'(PSEL), 32'h0);
        chk("abort_penable", 32'(PENABLE), 32'h0);
        chk("abort_paddr", PADDR, 32'h0);
        chk("abort_pwdata", PWDATA, 32'h0);
        chk("abort_ready", 32'(cpuReady), 32'h0);
        chk("abort_err", 32'(cpuErr), 32'h0);
        chk("abort_rdata", cpuRData, 32'h0);
        cpuReq = 1'b0;
        set_slaves(3, 1'b1, 32'h9999_9999, 1'b0);
        @(negedge clk);
        chk("abort_hold_ready", 32'(cpuReady), 32'h0);
        chk("abort_hold_psel", 32'(PSEL), 32'h0);
        reset = 1'b1;
        set_slaves(-1, 1'b1, '0, 1'b0);
        run(tbl[0]);

        // Slave that never raises PREADY.
        drive_req(1'b0, 32'h1000_1000, 32'h0, 4'b1111);
        set_slaves(1, 1'b0, 32'h0000_0055, 1'b0);
`ifdef APB_TIMEOUT_EN
        e.err   = 1'b1;
        e.rdata = 32'hDEAD_BEEF;
`else
        e.err   = 1'b0;
        e.rdata = 32'h0000_0055;
`endif
        sb.push_back(e);
        repeat (2) @(negedge clk);
        n = 0;
        done = 1'b0;
        while (!done && n < 120) begin
            @(posedge clk);
            #1;
`ifndef APB_TIMEOUT_EN
            if (n == 100) set_slaves(1, 1'b1, 32'h0000_0055, 1'b0);
`endif
            @(negedge clk);
            if (n == 99) begin
                chk("hang_ready", 32'(cpuReady), 32'h0);
                chk("hang_penable", 32'(PENABLE), 32'h1);
                chk("hang_psel", 32'(PSEL), 32'h2);
            end
            if (cpuReady) begin
                done = 1'b1;
                pop_chk("hang_cmp");
`ifdef APB_TIMEOUT_EN
                chk("hang_latency", 32'(n), 32'd16);
`else
                chk("hang_latency", 32'(n), 32'd100);
`endif
            end else begin
                n++;
            end
        end
        if (!done) chk("hang_no_completion", 32'h0, 32'h1);
        @(posedge clk);
        #1;
        cpuReq = 1'b0;
        set_slaves(-1, 1'b1, '0, 1'b0);
        @(negedge clk);
        chk("hang_post_psel", 32'(PSEL), 32'h0);
        chk("hang_post_penable", 32'(PENABLE), 32'h0);

        chk("sb_drained", 32'(sb.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
